// File: rtl/ocl_timeout_shim_if.sv
// -----------------------------------------------------------------------------
// axi_bus_t : single-beat AXI4 / AXI-Lite style bus with 32-bit data.
//
// Modports are named after the agent that the owning module talks to:
//   master : held by a module whose far side is a bus master. It receives
//            AW/W/AR requests and drives B/R responses.
//   slave  : held by a module whose far side is a bus slave. It drives
//            AW/W/AR requests and receives B/R responses.
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where both valid and ready are high. Once valid is raised it is held, with
// its payload stable, until that transfer happens. Ready may depend on valid.
// -----------------------------------------------------------------------------
interface axi_bus_t;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  awaddr, awid, awlen, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  araddr, arid, arlen, arsize, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport slave (
    output awaddr, awid, awlen, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output araddr, arid, arlen, arsize, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/ocl_timeout_shim.sv
// -----------------------------------------------------------------------------
// ocl_timeout_shim
//   Sits between the shell OCL AXI-Lite master and ocl_slave. Forwards one
//   host transaction at a time and watches the downstream response. If the
//   response does not arrive within TIMEOUT_CYCLES of issue, the host gets an
//   SLVERR answer (and ERR_RDATA for reads), so the MMIO path never wedges.
//   The late downstream response is then drained and discarded before any
//   new host request is accepted.
//
// Parameters
//   TIMEOUT_CYCLES : cycles from downstream issue to forced error (2..65535)
//   ERR_RDATA      : read data returned on a read timeout
//
// Ports
//   clk           : clock
//   rst           : asynchronous, active-high reset
//   host          : shell-facing side (axi_bus_t.master)
//   dev           : ocl_slave-facing side (axi_bus_t.slave)
//   timeout_count : saturating count of forced-error responses
//   dbg_state_o   : current FSM state encoding, for observation only
//
// Build option
//   OCL_TIMEOUT_CNT_EN : when defined, timeout_count is a real saturating
//                        counter; otherwise it is tied to zero with no flops.
// -----------------------------------------------------------------------------
module ocl_timeout_shim #(
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  axi_bus_t.master    host,
  axi_bus_t.slave     dev,
  output logic [15:0] timeout_count,
  output logic [3:0]  dbg_state_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_HOST_W   = 4'd1,
    S_DEV_WR   = 4'd2,
    S_WAIT_B   = 4'd3,
    S_HOST_B   = 4'd4,
    S_DRAIN_WR = 4'd5,
    S_DEV_AR   = 4'd6,
    S_WAIT_R   = 4'd7,
    S_HOST_R   = 4'd8,
    S_DRAIN_R  = 4'd9
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;
  logic [15:0] timer_q, timer_d;
  // *_pend_q drive the downstream valids directly. They are raised on issue
  // and cleared only by the matching handshake, independent of state, so a
  // valid is never withdrawn when a timeout moves the FSM elsewhere.
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;
  logic        ar_pend_q, ar_pend_d;
  // Set on timeout: the next downstream response belongs to an abandoned
  // transaction and must be swallowed.
  logic        drain_q, drain_d;

  logic dev_aw_hs, dev_w_hs, dev_ar_hs, dev_b_hs, dev_r_hs;
  logic timed, timeout;

  assign dev_aw_hs = dev.awvalid & dev.awready;
  assign dev_w_hs  = dev.wvalid  & dev.wready;
  assign dev_ar_hs = dev.arvalid & dev.arready;
  assign dev_b_hs  = dev.bvalid  & dev.bready;
  assign dev_r_hs  = dev.rvalid  & dev.rready;

  // The watchdog only runs for a live transaction; while draining there is
  // nobody left to answer, so the shim waits as long as it takes.
  assign timed = !drain_q && ((state_q == S_DEV_WR) || (state_q == S_WAIT_B) ||
                              (state_q == S_DEV_AR) || (state_q == S_WAIT_R));
  // A real response arriving on the final cycle takes precedence.
  assign timeout = timed && (timer_q == TIMER_LAST) && !dev_b_hs && !dev_r_hs;

`ifdef OCL_TIMEOUT_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    if (timeout && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end
  assign timeout_count = cnt_q;
`else
  assign timeout_count = 16'h0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    drain_d   = drain_q;
    aw_pend_d = aw_pend_q & ~dev_aw_hs;
    w_pend_d  = w_pend_q  & ~dev_w_hs;
    ar_pend_d = ar_pend_q & ~dev_ar_hs;
    timer_d   = timed ? (timer_q + 16'd1) : timer_q;

    unique case (state_q)
      S_IDLE: begin
        if (host.awvalid) begin
          addr_d  = host.awaddr;
          state_d = S_HOST_W;
        end else if (host.arvalid) begin
          addr_d    = host.araddr;
          ar_pend_d = 1'b1;
          timer_d   = 16'd0;
          state_d   = S_DEV_AR;
        end
      end
      S_HOST_W: begin
        if (host.wvalid) begin
          wdata_d   = host.wdata;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          timer_d   = 16'd0;
          state_d   = S_DEV_WR;
        end
      end
      S_DEV_WR: begin
        if (timeout) begin
          resp_d  = RESP_SLVERR;
          drain_d = 1'b1;
          state_d = S_HOST_B;
        end else if (!aw_pend_d && !w_pend_d) begin
          state_d = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (dev_b_hs) begin
          if (drain_q) begin
            drain_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            resp_d  = dev.bresp;
            state_d = S_HOST_B;
          end
        end else if (timeout) begin
          resp_d  = RESP_SLVERR;
          drain_d = 1'b1;
          state_d = S_HOST_B;
        end
      end
      S_HOST_B: begin
        if (host.bready) state_d = drain_q ? S_DRAIN_WR : S_IDLE;
      end
      S_DRAIN_WR: begin
        if (!aw_pend_d && !w_pend_d) state_d = S_WAIT_B;
      end
      S_DEV_AR: begin
        if (timeout) begin
          rdata_d = ERR_RDATA;
          resp_d  = RESP_SLVERR;
          drain_d = 1'b1;
          state_d = S_HOST_R;
        end else if (!ar_pend_d) begin
          state_d = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (dev_r_hs) begin
          rdata_d = dev.rdata;
          resp_d  = dev.rresp;
          state_d = S_HOST_R;
        end else if (timeout) begin
          rdata_d = ERR_RDATA;
          resp_d  = RESP_SLVERR;
          drain_d = 1'b1;
          state_d = S_HOST_R;
        end
      end
      S_HOST_R: begin
        if (host.rready) state_d = drain_q ? S_DRAIN_R : S_IDLE;
      end
      S_DRAIN_R: begin
        if (dev_r_hs) begin
          drain_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      timer_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      ar_pend_q <= 1'b0;
      drain_q   <= 1'b0;
`ifdef OCL_TIMEOUT_CNT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      timer_q   <= timer_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      ar_pend_q <= ar_pend_d;
      drain_q   <= drain_d;
`ifdef OCL_TIMEOUT_CNT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Host side. AR is held off while AW is offered so a simultaneous pair
  // resolves as write-first without dropping the read request.
  assign host.awready = (state_q == S_IDLE);
  assign host.arready = (state_q == S_IDLE) && !host.awvalid;
  assign host.wready  = (state_q == S_HOST_W);
  assign host.bvalid  = (state_q == S_HOST_B);
  assign host.bresp   = resp_q;
  assign host.bid     = 4'd0;
  assign host.rvalid  = (state_q == S_HOST_R);
  assign host.rdata   = rdata_q;
  assign host.rresp   = resp_q;
  assign host.rid     = 4'd0;
  assign host.rlast   = 1'b1;

  // Device side: always single-beat, full-word, ID 0.
  assign dev.awvalid = aw_pend_q;
  assign dev.awaddr  = addr_q;
  assign dev.awid    = 4'd0;
  assign dev.awlen   = 8'd0;
  assign dev.awsize  = 3'd2;
  assign dev.wvalid  = w_pend_q;
  assign dev.wdata   = wdata_q;
  assign dev.wstrb   = 4'hF;
  assign dev.wlast   = 1'b1;
  assign dev.bready  = (state_q == S_WAIT_B);
  assign dev.arvalid = ar_pend_q;
  assign dev.araddr  = addr_q;
  assign dev.arid    = 4'd0;
  assign dev.arlen   = 8'd0;
  assign dev.arsize  = 3'd2;
  assign dev.rready  = (state_q == S_WAIT_R) || (state_q == S_DRAIN_R);

  assign dbg_state_o = state_q;

  // Fields the shim accepts but has no use for (single-beat, ID-less).
  logic unused_ok;
  assign unused_ok = ^{host.awid, host.awlen, host.awsize, host.wstrb, host.wlast,
                       host.arid, host.arlen, host.arsize,
                       dev.bid, dev.rid, dev.rlast};

endmodule

// File: tb/tb_ocl_timeout_shim.sv
// -----------------------------------------------------------------------------
// tb_ocl_timeout_shim
//   Directed bench for ocl_timeout_shim with TIMEOUT_CYCLES=16. Inputs are
//   driven 1ns after the rising edge; outputs are read at that point or later.
// -----------------------------------------------------------------------------
module tb_ocl_timeout_shim;
  localparam int TO = 16;
`ifdef OCL_TIMEOUT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] timeout_count;
  logic [3:0]  dbg_state;
  int total = 0;
  int bad   = 0;
  int n;

  axi_bus_t host_bus();
  axi_bus_t dev_bus();

  ocl_timeout_shim #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (host_bus),
    .dev          (dev_bus),
    .timeout_count(timeout_count),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- helpers ----------------
  function automatic logic [31:0] exp_cnt(input int k);
    return CNT_EN ? 32'(k) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AW then W handshake on the host side; returns in the first DEV_WR cycle.
  task automatic host_write(input logic [31:0] a, input logic [31:0] d);
    int k;
    host_bus.awaddr  = a;
    host_bus.awvalid = 1'b1;
    k = 0;
    while (!host_bus.awready && k < 50) begin tick(); k++; end
    chk("aw_accept", 32'(k < 50), 32'd1);
    tick();
    host_bus.awvalid = 1'b0;
    host_bus.wdata   = d;
    host_bus.wvalid  = 1'b1;
    k = 0;
    while (!host_bus.wready && k < 50) begin tick(); k++; end
    chk("w_accept", 32'(k < 50), 32'd1);
    tick();
    host_bus.wvalid = 1'b0;
  endtask

  task automatic wait_host_rvalid(output int k);
    k = 0;
    while (!host_bus.rvalid && k < 100) begin tick(); k++; end
  endtask

  task automatic wait_host_bvalid(output int k);
    k = 0;
    while (!host_bus.bvalid && k < 100) begin tick(); k++; end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    host_bus.awaddr = '0; host_bus.awid = '0; host_bus.awlen = '0; host_bus.awsize = '0;
    host_bus.awvalid = 1'b0;
    host_bus.wdata = '0; host_bus.wstrb = 4'hF; host_bus.wlast = 1'b1; host_bus.wvalid = 1'b0;
    host_bus.bready = 1'b1;
    host_bus.araddr = '0; host_bus.arid = '0; host_bus.arlen = '0; host_bus.arsize = '0;
    host_bus.arvalid = 1'b0;
    host_bus.rready = 1'b1;
    dev_bus.awready = 1'b1; dev_bus.wready = 1'b1; dev_bus.arready = 1'b1;
    dev_bus.bid = '0; dev_bus.bresp = '0; dev_bus.bvalid = 1'b0;
    dev_bus.rid = '0; dev_bus.rdata = '0; dev_bus.rresp = '0; dev_bus.rlast = 1'b1;
    dev_bus.rvalid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dev_awvalid", 32'(dev_bus.awvalid), 32'd0);
    chk("rst_dev_wvalid", 32'(dev_bus.wvalid), 32'd0);
    chk("rst_dev_arvalid", 32'(dev_bus.arvalid), 32'd0);
    chk("rst_host_bvalid", 32'(host_bus.bvalid), 32'd0);
    chk("rst_host_rvalid", 32'(host_bus.rvalid), 32'd0);
    chk("rst_count", 32'(timeout_count), 32'd0);
    chk("rst_awready", 32'(host_bus.awready), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    tick();

    // 1: plain write, device answers OKAY a few cycles later
    host_write(32'h0000_0010, 32'h0000_1234);
    chk("t1_dev_awvalid", 32'(dev_bus.awvalid), 32'd1);
    chk("t1_dev_wvalid", 32'(dev_bus.wvalid), 32'd1);
    chk("t1_dev_awaddr", dev_bus.awaddr, 32'h0000_0010);
    chk("t1_dev_wdata", dev_bus.wdata, 32'h0000_1234);
    chk("t1_dev_wstrb", 32'(dev_bus.wstrb), 32'hF);
    chk("t1_dev_awsize", 32'(dev_bus.awsize), 32'd2);
    tick();
    chk("t1_dev_bready", 32'(dev_bus.bready), 32'd1);
    chk("t1_dev_awvalid_drop", 32'(dev_bus.awvalid), 32'd0);
    tick(); tick();
    chk("t1_host_bvalid_early", 32'(host_bus.bvalid), 32'd0);
    dev_bus.bresp = 2'b00; dev_bus.bvalid = 1'b1;
    tick();
    dev_bus.bvalid = 1'b0;
    chk("t1_host_bvalid", 32'(host_bus.bvalid), 32'd1);
    chk("t1_host_bresp", 32'(host_bus.bresp), 32'd0);
    tick();
    chk("t1_idle_awready", 32'(host_bus.awready), 32'd1);
    chk("t1_host_bvalid_done", 32'(host_bus.bvalid), 32'd0);
    chk("t1_count", 32'(timeout_count), 32'd0);

    // 2: plain read, device answers OKAY
    host_bus.araddr = 32'h0000_0024; host_bus.arvalid = 1'b1;
    #1;
    chk("t2_arready", 32'(host_bus.arready), 32'd1);
    tick();
    host_bus.arvalid = 1'b0;
    chk("t2_dev_arvalid", 32'(dev_bus.arvalid), 32'd1);
    chk("t2_dev_araddr", dev_bus.araddr, 32'h0000_0024);
    tick();
    chk("t2_dev_rready", 32'(dev_bus.rready), 32'd1);
    chk("t2_dev_arvalid_drop", 32'(dev_bus.arvalid), 32'd0);
    dev_bus.rdata = 32'hCAFE_F00D; dev_bus.rresp = 2'b00; dev_bus.rvalid = 1'b1;
    tick();
    dev_bus.rvalid = 1'b0;
    chk("t2_host_rvalid", 32'(host_bus.rvalid), 32'd1);
    chk("t2_host_rdata", host_bus.rdata, 32'hCAFE_F00D);
    chk("t2_host_rresp", 32'(host_bus.rresp), 32'd0);
    tick();
    chk("t2_host_rvalid_done", 32'(host_bus.rvalid), 32'd0);

    // 3: read that the device never answers
    host_bus.araddr = 32'h0000_0040; host_bus.arvalid = 1'b1;
    tick();
    host_bus.arvalid = 1'b0;
    chk("t3_dev_arvalid", 32'(dev_bus.arvalid), 32'd1);
    wait_host_rvalid(n);
    chk("t3_latency", 32'(n), 32'd16);
    chk("t3_err_rdata", host_bus.rdata, 32'hDEAD_BEEF);
    chk("t3_err_rresp", 32'(host_bus.rresp), 32'd2);
    chk("t3_count", 32'(timeout_count), exp_cnt(1));
    tick();
    chk("t3_rvalid_gone", 32'(host_bus.rvalid), 32'd0);
    chk("t3_drain_arready", 32'(host_bus.arready), 32'd0);
    chk("t3_drain_rready", 32'(dev_bus.rready), 32'd1);
    repeat (3) tick();
    chk("t3_drain_hold", 32'(host_bus.arready), 32'd0);
    dev_bus.rdata = 32'h0000_0001; dev_bus.rresp = 2'b00; dev_bus.rvalid = 1'b1;
    tick();
    dev_bus.rvalid = 1'b0;
    chk("t3_absorbed", 32'(host_bus.rvalid), 32'd0);
    chk("t3_arready_back", 32'(host_bus.arready), 32'd1);

    // 4: device stalls awready for ~40 cycles
    dev_bus.awready = 1'b0;
    host_write(32'h0000_0050, 32'h0000_ABCD);
    chk("t4_dev_awvalid", 32'(dev_bus.awvalid), 32'd1);
    wait_host_bvalid(n);
    chk("t4_latency", 32'(n), 32'd16);
    chk("t4_err_bresp", 32'(host_bus.bresp), 32'd2);
    chk("t4_awvalid_held", 32'(dev_bus.awvalid), 32'd1);
    chk("t4_wvalid_done", 32'(dev_bus.wvalid), 32'd0);
    chk("t4_count", 32'(timeout_count), exp_cnt(2));
    tick();
    chk("t4_bvalid_gone", 32'(host_bus.bvalid), 32'd0);
    chk("t4_drain_awready", 32'(host_bus.awready), 32'd0);
    repeat (23) tick();
    chk("t4_awvalid_still", 32'(dev_bus.awvalid), 32'd1);
    dev_bus.awready = 1'b1;
    tick();
    chk("t4_awvalid_drop", 32'(dev_bus.awvalid), 32'd0);
    chk("t4_drain_bready", 32'(dev_bus.bready), 32'd1);
    chk("t4_still_busy", 32'(host_bus.awready), 32'd0);
    dev_bus.bresp = 2'b00; dev_bus.bvalid = 1'b1;
    tick();
    dev_bus.bvalid = 1'b0;
    chk("t4_no_host_b", 32'(host_bus.bvalid), 32'd0);
    chk("t4_idle", 32'(host_bus.awready), 32'd1);

    // 5: simultaneous AW/AR, write response lands on the last timer cycle
    host_bus.awaddr = 32'h0000_0060; host_bus.awvalid = 1'b1;
    host_bus.araddr = 32'h0000_0064; host_bus.arvalid = 1'b1;
    #1;
    chk("t5_awready", 32'(host_bus.awready), 32'd1);
    chk("t5_arready_blocked", 32'(host_bus.arready), 32'd0);
    tick();
    host_bus.awvalid = 1'b0;
    host_bus.wdata = 32'h0000_5555; host_bus.wvalid = 1'b1;
    #1;
    chk("t5_arready_hw", 32'(host_bus.arready), 32'd0);
    tick();
    host_bus.wvalid = 1'b0;
    tick();
    chk("t5_bready", 32'(dev_bus.bready), 32'd1);
    repeat (14) tick();
    chk("t5_no_early_timeout", 32'(host_bus.bvalid), 32'd0);
    dev_bus.bresp = 2'b00; dev_bus.bvalid = 1'b1;
    tick();
    dev_bus.bvalid = 1'b0;
    chk("t5_host_bvalid", 32'(host_bus.bvalid), 32'd1);
    chk("t5_real_bresp", 32'(host_bus.bresp), 32'd0);
    chk("t5_count_same", 32'(timeout_count), exp_cnt(2));
    tick();
    chk("t5_arready_now", 32'(host_bus.arready), 32'd1);
    tick();
    host_bus.arvalid = 1'b0;
    chk("t5_dev_arvalid", 32'(dev_bus.arvalid), 32'd1);
    chk("t5_dev_araddr", dev_bus.araddr, 32'h0000_0064);
    tick();
    dev_bus.rdata = 32'h0000_0077; dev_bus.rresp = 2'b00; dev_bus.rvalid = 1'b1;
    tick();
    dev_bus.rvalid = 1'b0;
    chk("t5_host_rvalid", 32'(host_bus.rvalid), 32'd1);
    chk("t5_host_rdata", host_bus.rdata, 32'h0000_0077);
    tick();

    // 6: asynchronous reset while waiting for B
    host_write(32'h0000_0070, 32'h0000_7070);
    tick();
    chk("t6_in_wait_b", 32'(dev_bus.bready), 32'd1);
    chk("t6_count_before", 32'(timeout_count), exp_cnt(2));
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_bready", 32'(dev_bus.bready), 32'd0);
    chk("t6_rst_awvalid", 32'(dev_bus.awvalid), 32'd0);
    chk("t6_rst_bvalid", 32'(host_bus.bvalid), 32'd0);
    chk("t6_rst_count", 32'(timeout_count), 32'd0);
    chk("t6_rst_awready", 32'(host_bus.awready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    host_write(32'h0000_0080, 32'h0000_8080);
    chk("t6_dev_wdata", dev_bus.wdata, 32'h0000_8080);
    tick();
    dev_bus.bresp = 2'b01; dev_bus.bvalid = 1'b1;
    tick();
    dev_bus.bvalid = 1'b0;
    chk("t6_host_bvalid", 32'(host_bus.bvalid), 32'd1);
    chk("t6_host_bresp", 32'(host_bus.bresp), 32'd1);
    tick();
    chk("t6_idle", 32'(host_bus.awready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "time limit reached");
  end
endmodule
